// File: rtl/l2_cache_pkg.sv
// Shared L2 cache types: coherence state encoding, eviction record layout
// and the default field widths used by the eviction path.
package l2_cache_pkg;

  localparam int TAG_W   = 16;
  localparam int SET_W   = 8;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    INVALID   = 2'd0,
    SHARED    = 2'd1,
    EXCLUSIVE = 2'd2,
    MODIFIED  = 2'd3
  } coh_state_e;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set;
    coh_state_e       state;
  } evict_rec_t;

endpackage

// File: rtl/l2_evict_fifo.sv
// Small synchronous FIFO for joined eviction records. Pushes into a full
// FIFO and pops from an empty one are ignored; pointers wrap modulo DEPTH.
module l2_evict_fifo #(
  parameter int DATA_W = 26,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [DATA_W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       count_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/l2_evict_writeback_queue.sv
// Joins the tag bank's three eviction channels into one record, queues valid
// victims, issues memory writebacks and tracks them until acknowledged.
module l2_evict_writeback_queue #(
  parameter int TAG_W   = l2_cache_pkg::TAG_W,
  parameter int SET_W   = l2_cache_pkg::SET_W,
  parameter int STATE_W = l2_cache_pkg::STATE_W,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tag_out_evict_valid,
  output logic                   tag_out_evict_ready,
  input  logic [TAG_W-1:0]       tag_out_evict_data,
  input  logic                   set_out_evict_valid,
  output logic                   set_out_evict_ready,
  input  logic [SET_W-1:0]       set_out_evict_data,
  input  logic                   state_out_evict_valid,
  output logic                   state_out_evict_ready,
  input  logic [STATE_W-1:0]     state_out_evict_data,
  output logic                   wb_req_valid,
  input  logic                   wb_req_ready,
  output logic [TAG_W+SET_W-1:0] wb_req_addr,
  output logic                   wb_req_dirty,
  input  logic                   wb_ack,
  output logic                   busy,
  output logic [7:0]             drop_cnt,
  output logic                   err_ack_underflow
);

  import l2_cache_pkg::*;

  localparam int REC_W = TAG_W + SET_W + STATE_W;
  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0]   MAX_OUT_C   = OUT_W'(MAX_OUT);
  localparam logic [STATE_W-1:0] ST_INVALID  = STATE_W'(INVALID);
  localparam logic [STATE_W-1:0] ST_MODIFIED = STATE_W'(MODIFIED);

  logic [TAG_W-1:0]   tag_q;
  logic [SET_W-1:0]   set_q;
  logic [STATE_W-1:0] state_q;
  logic               tag_held_q;
  logic               set_held_q;
  logic               state_held_q;

  logic [OUT_W-1:0]   out_cnt_q;
  logic [OUT_W-1:0]   out_cnt_d;
  logic [7:0]         drop_cnt_q;
  logic [7:0]         drop_cnt_d;
  logic               err_q;
  logic               err_d;

  logic               tag_hs;
  logic               set_hs;
  logic               state_hs;
  logic               rec_invalid;
  logic               join_fire;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;
  logic [REC_W-1:0]   fifo_head;
  logic               wb_pop;

  // Join: an INVALID record always leaves (it is dropped), a real victim needs FIFO room.
  assign rec_invalid = (state_q == ST_INVALID);
  assign join_fire   = tag_held_q && set_held_q && state_held_q &&
                       (rec_invalid || !fifo_full);
  assign fifo_push   = join_fire && !rec_invalid;

  // A channel accepts when its slot is empty or is being vacated this cycle.
  assign tag_out_evict_ready   = rst && (!tag_held_q   || join_fire);
  assign set_out_evict_ready   = rst && (!set_held_q   || join_fire);
  assign state_out_evict_ready = rst && (!state_held_q || join_fire);

  assign tag_hs   = tag_out_evict_valid   && tag_out_evict_ready;
  assign set_hs   = set_out_evict_valid   && set_out_evict_ready;
  assign state_hs = state_out_evict_valid && state_out_evict_ready;

  // Per-channel hold registers: capture on handshake, release on join.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q        <= '0;
      set_q        <= '0;
      state_q      <= '0;
      tag_held_q   <= 1'b0;
      set_held_q   <= 1'b0;
      state_held_q <= 1'b0;
    end else begin
      if (tag_hs) begin
        tag_q      <= tag_out_evict_data;
        tag_held_q <= 1'b1;
      end else if (join_fire) begin
        tag_held_q <= 1'b0;
      end
      if (set_hs) begin
        set_q      <= set_out_evict_data;
        set_held_q <= 1'b1;
      end else if (join_fire) begin
        set_held_q <= 1'b0;
      end
      if (state_hs) begin
        state_q      <= state_out_evict_data;
        state_held_q <= 1'b1;
      end else if (join_fire) begin
        state_held_q <= 1'b0;
      end
    end
  end

  l2_evict_fifo #(
    .DATA_W (REC_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push),
    .push_data_i ({tag_q, set_q, state_q}),
    .pop_i       (wb_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  // Request side: head entry is presented only while the outstanding window has room.
  assign wb_req_valid = !fifo_empty && (out_cnt_q < MAX_OUT_C);
  assign wb_req_addr  = fifo_head[REC_W-1:STATE_W];
  assign wb_req_dirty = (fifo_head[STATE_W-1:0] == ST_MODIFIED);
  assign wb_pop       = wb_req_valid && wb_req_ready;

  // Next-state for outstanding count, drop counter and the sticky underflow flag.
  always_comb begin
    out_cnt_d  = out_cnt_q;
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;
    if (wb_pop && !wb_ack) begin
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end else if (!wb_pop && wb_ack) begin
      if (out_cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        out_cnt_d = out_cnt_q - OUT_W'(1);
      end
    end
    if (join_fire && rec_invalid && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Counter and status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign drop_cnt          = drop_cnt_q;
  assign err_ack_underflow = err_q;
  assign busy              = tag_held_q || set_held_q || state_held_q ||
                             !fifo_empty || (out_cnt_q != '0);

endmodule

// File: tb/tb_l2_evict_writeback_queue.sv
// Self-checking bench for l2_evict_writeback_queue: table-driven records with
// a writeback scoreboard, plus hand-written multi-cycle corner sequences.
module tb_l2_evict_writeback_queue;
  import l2_cache_pkg::*;

  logic        clk;
  logic        rst;
  logic        tagValid;
  logic [15:0] tagData;
  logic        setValid;
  logic [7:0]  setData;
  logic        stateValid;
  logic [1:0]  stateData;
  logic        wbReady;
  logic        wbAck;

  logic        tag_ready;
  logic        set_ready;
  logic        state_ready;
  logic        wb_req_valid;
  logic [23:0] wb_req_addr;
  logic        wb_req_dirty;
  logic        busy;
  logic [7:0]  drop_cnt;
  logic        err_ack_underflow;

  typedef struct packed {
    logic [23:0] addr;
    logic        dirty;
  } exp_t;

  typedef struct packed {
    logic [15:0] tag;
    logic [7:0]  set;
    logic [1:0]  state;
    logic [23:0] expAddr;
    logic        expDirty;
    logic        expPush;
  } vec_t;

  exp_t sbQ[$];
  vec_t vecs[6];
  int   testsRun  = 0;
  int   failCount = 0;
  int   popCount  = 0;
  int   ackCount  = 0;
  int   expDrop   = 0;

  l2_evict_writeback_queue dut (
    .clk                   (clk),
    .rst                   (rst),
    .tag_out_evict_valid   (tagValid),
    .tag_out_evict_ready   (tag_ready),
    .tag_out_evict_data    (tagData),
    .set_out_evict_valid   (setValid),
    .set_out_evict_ready   (set_ready),
    .set_out_evict_data    (setData),
    .state_out_evict_valid (stateValid),
    .state_out_evict_ready (state_ready),
    .state_out_evict_data  (stateData),
    .wb_req_valid          (wb_req_valid),
    .wb_req_ready          (wbReady),
    .wb_req_addr           (wb_req_addr),
    .wb_req_dirty          (wb_req_dirty),
    .wb_ack                (wbAck),
    .busy                  (busy),
    .drop_cnt              (drop_cnt),
    .err_ack_underflow     (err_ack_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expectReq(input logic [23:0] addr, input logic dirty);
    exp_t e;
    e.addr  = addr;
    e.dirty = dirty;
    sbQ.push_back(e);
  endtask

  // Offer all three fields at once; each drops its valid after its own handshake.
  task automatic applyStimulus(input logic [15:0] t, input logic [7:0] s, input logic [1:0] st);
    bit tDone = 0, sDone = 0, stDone = 0;
    bit tHs, sHs, stHs;
    int budget = 0;
    tagValid = 1'b1;   tagData   = t;
    setValid = 1'b1;   setData   = s;
    stateValid = 1'b1; stateData = st;
    while (!(tDone && sDone && stDone) && budget < 50) begin
      @(negedge clk);
      tHs  = tagValid && tag_ready;
      sHs  = setValid && set_ready;
      stHs = stateValid && state_ready;
      nextCycle();
      if (tHs)  begin tagValid = 1'b0;   tDone  = 1; end
      if (sHs)  begin setValid = 1'b0;   sDone  = 1; end
      if (stHs) begin stateValid = 1'b0; stDone = 1; end
      budget++;
    end
    if (!(tDone && sDone && stDone)) begin
      checkOutput("field handshake timeout", 32'(budget), 32'd0);
      tagValid = 1'b0; setValid = 1'b0; stateValid = 1'b0;
    end
  endtask

  task automatic ackOnce();
    wbAck = 1'b1;
    ackCount++;
    nextCycle();
    wbAck = 1'b0;
  endtask

  // Accept requests, ack every issued writeback, stop once the block is idle.
  task automatic drain();
    int budget = 0;
    wbReady = 1'b1;
    forever begin
      @(negedge clk);
      if (!busy) break;
      budget++;
      if (budget > 100) begin
        checkOutput("drain timeout busy", 32'(busy), 32'd0);
        break;
      end
      nextCycle();
      wbAck = (popCount > ackCount);
      if (wbAck) ackCount++;
    end
    nextCycle();
    wbAck = 1'b0;
  endtask

  // Scoreboard: every accepted writeback must match the oldest expected record.
  always @(negedge clk) begin
    if (rst && wb_req_valid && wbReady) begin
      exp_t e;
      popCount++;
      if (sbQ.size() == 0) begin
        checkOutput("unexpected wb_req_valid", 32'(wb_req_valid), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("wb_req_addr", 32'(wb_req_addr), 32'(e.addr));
        checkOutput("wb_req_dirty", 32'(wb_req_dirty), 32'(e.dirty));
      end
    end
  end

  // Hard time limit so a stuck design still terminates.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: time limit reached, tests run %0d", testsRun);
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    int p0;
    vecs[0] = '{16'h1234, 8'h56, MODIFIED,  24'h123456, 1'b1, 1'b1};
    vecs[1] = '{16'hBEEF, 8'h01, SHARED,    24'hBEEF01, 1'b0, 1'b1};
    vecs[2] = '{16'h0000, 8'hFF, EXCLUSIVE, 24'h0000FF, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 8'h00, INVALID,   24'hFFFF00, 1'b0, 1'b0};
    vecs[4] = '{16'hA5A5, 8'h5A, MODIFIED,  24'hA5A55A, 1'b1, 1'b1};
    vecs[5] = '{16'h0F0F, 8'h80, INVALID,   24'h0F0F80, 1'b0, 1'b0};

    rst = 1'b1; tagValid = 0; setValid = 0; stateValid = 0;
    tagData = '0; setData = '0; stateData = '0; wbReady = 0; wbAck = 0;
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    checkOutput("reset tag_ready", 32'(tag_ready), 32'd0);
    checkOutput("reset set_ready", 32'(set_ready), 32'd0);
    checkOutput("reset state_ready", 32'(state_ready), 32'd0);
    checkOutput("reset wb_req_valid", 32'(wb_req_valid), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("reset err", 32'(err_ack_underflow), 32'd0);
    nextCycle(); nextCycle();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("post-reset tag_ready", 32'(tag_ready), 32'd1);

    // Staggered arrival: tag in cycle 2, state in 3, set in 5 -> request in cycle 7
    wbReady = 1'b1;
    nextCycle(); nextCycle();
    tagValid = 1'b1; tagData = 16'h1A2B;
    nextCycle();
    tagValid = 1'b0; stateValid = 1'b1; stateData = MODIFIED;
    @(negedge clk);
    checkOutput("c3 tag_ready held", 32'(tag_ready), 32'd0);
    nextCycle();
    stateValid = 1'b0;
    @(negedge clk);
    checkOutput("c4 tag_ready held", 32'(tag_ready), 32'd0);
    checkOutput("c4 state_ready held", 32'(state_ready), 32'd0);
    checkOutput("c4 set_ready open", 32'(set_ready), 32'd1);
    nextCycle();
    setValid = 1'b1; setData = 8'h07;
    expectReq(24'h1A2B07, 1'b1);
    nextCycle();
    setValid = 1'b0;
    @(negedge clk);
    checkOutput("c6 wb_req_valid", 32'(wb_req_valid), 32'd0);
    checkOutput("c6 tag_ready on join", 32'(tag_ready), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("c7 wb_req_valid", 32'(wb_req_valid), 32'd1);
    checkOutput("c7 wb_req_addr", 32'(wb_req_addr), 32'h1A2B07);
    checkOutput("c7 wb_req_dirty", 32'(wb_req_dirty), 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("c8 busy outstanding", 32'(busy), 32'd1);
    checkOutput("c8 wb_req_valid", 32'(wb_req_valid), 32'd0);
    ackOnce();
    @(negedge clk);
    checkOutput("busy after ack", 32'(busy), 32'd0);

    // Table-driven records
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].expPush) expectReq(vecs[i].expAddr, vecs[i].expDirty);
      nextCycle();
      applyStimulus(vecs[i].tag, vecs[i].set, vecs[i].state);
      drain();
      if (!vecs[i].expPush) expDrop++;
      checkOutput($sformatf("vec%0d drop_cnt", i), 32'(drop_cnt), 32'(expDrop));
    end

    // Drop counter saturation
    for (int i = 0; i < 260; i++) begin
      applyStimulus(16'(i), 8'(i), INVALID);
      if (expDrop < 255) expDrop++;
    end
    nextCycle(); nextCycle();
    @(negedge clk);
    checkOutput("drop_cnt saturated", 32'(drop_cnt), 32'(expDrop));
    checkOutput("drops leave idle", 32'(busy), 32'd0);

    // Fill FIFO past depth with memory stalled; order must survive pointer wrap
    nextCycle();
    wbReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expectReq({16'hC000 + 16'(i), 8'h10 + 8'(i)}, i[0]);
      applyStimulus(16'hC000 + 16'(i), 8'h10 + 8'(i), i[0] ? MODIFIED : SHARED);
    end
    nextCycle();
    @(negedge clk);
    checkOutput("full tag_ready", 32'(tag_ready), 32'd0);
    checkOutput("full set_ready", 32'(set_ready), 32'd0);
    checkOutput("full state_ready", 32'(state_ready), 32'd0);
    nextCycle(); nextCycle();
    @(negedge clk);
    checkOutput("full tag_ready stays low", 32'(tag_ready), 32'd0);
    nextCycle();
    wbReady = 1'b1;
    nextCycle();
    wbReady = 1'b0;
    @(negedge clk);
    checkOutput("fifth joins after pop", 32'(tag_ready), 32'd1);
    drain();

    // Outstanding limit: three queued, no acks -> exactly two issue
    nextCycle();
    wbReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expectReq({16'h7700 + 16'(i), 8'h20 + 8'(i)}, 1'b0);
      applyStimulus(16'h7700 + 16'(i), 8'h20 + 8'(i), EXCLUSIVE);
    end
    nextCycle(); nextCycle();
    p0 = popCount;
    wbReady = 1'b1;
    repeat (6) nextCycle();
    checkOutput("pops at window limit", 32'(popCount - p0), 32'd2);
    @(negedge clk);
    checkOutput("valid blocked at limit", 32'(wb_req_valid), 32'd0);
    nextCycle();
    ackOnce();
    @(negedge clk);
    checkOutput("valid after one ack", 32'(wb_req_valid), 32'd1);
    nextCycle(); nextCycle();
    checkOutput("third pop", 32'(popCount - p0), 32'd3);
    wbAck = 1'b1; ackCount++;
    @(negedge clk);
    checkOutput("busy during first ack", 32'(busy), 32'd1);
    nextCycle();
    ackCount++;
    @(negedge clk);
    checkOutput("busy during final ack", 32'(busy), 32'd1);
    nextCycle();
    wbAck = 1'b0;
    @(negedge clk);
    checkOutput("busy after final ack", 32'(busy), 32'd0);
    checkOutput("scoreboard drained", 32'(sbQ.size()), 32'd0);

    // Ack with nothing outstanding
    nextCycle();
    wbAck = 1'b1;
    nextCycle();
    wbAck = 1'b0;
    @(negedge clk);
    checkOutput("underflow flag set", 32'(err_ack_underflow), 32'd1);
    checkOutput("underflow keeps idle", 32'(busy), 32'd0);
    repeat (3) nextCycle();
    @(negedge clk);
    checkOutput("underflow flag sticky", 32'(err_ack_underflow), 32'd1);
    checkOutput("out_cnt stays zero", 32'(busy), 32'd0);

    // Reset mid-operation: 1 outstanding, 2 queued, tag held
    nextCycle();
    wbReady = 1'b1;
    expectReq(24'h111101, 1'b1);
    applyStimulus(16'h1111, 8'h01, MODIFIED);
    nextCycle();
    nextCycle();
    wbReady = 1'b0;
    expectReq(24'h222202, 1'b0);
    applyStimulus(16'h2222, 8'h02, SHARED);
    expectReq(24'h333303, 1'b0);
    applyStimulus(16'h3333, 8'h03, SHARED);
    tagValid = 1'b1; tagData = 16'h4444;
    nextCycle();
    tagValid = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset busy", 32'(busy), 32'd1);
    checkOutput("pre-reset tag held", 32'(tag_ready), 32'd0);
    nextCycle();
    rst = 1'b0;
    sbQ.delete();
    popCount = 0; ackCount = 0; expDrop = 0;
    @(negedge clk);
    checkOutput("mid-reset wb_req_valid", 32'(wb_req_valid), 32'd0);
    checkOutput("mid-reset busy", 32'(busy), 32'd0);
    checkOutput("mid-reset tag_ready", 32'(tag_ready), 32'd0);
    checkOutput("mid-reset set_ready", 32'(set_ready), 32'd0);
    checkOutput("mid-reset state_ready", 32'(state_ready), 32'd0);
    checkOutput("mid-reset drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("mid-reset err", 32'(err_ack_underflow), 32'd0);
    nextCycle();
    @(negedge clk);
    checkOutput("reset next-cycle busy", 32'(busy), 32'd0);
    checkOutput("reset next-cycle valid", 32'(wb_req_valid), 32'd0);
    nextCycle();
    rst = 1'b1;
    wbReady = 1'b1;
    @(negedge clk);
    checkOutput("release tag_ready", 32'(tag_ready), 32'd1);
    checkOutput("release set_ready", 32'(set_ready), 32'd1);
    checkOutput("release state_ready", 32'(state_ready), 32'd1);
    repeat (5) nextCycle();
    @(negedge clk);
    checkOutput("no request after reset", 32'(wb_req_valid), 32'd0);
    checkOutput("idle after reset", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/l2_evict_writeback_queue.md
Name: l2_evict_writeback_queue

Overview:
- Sits directly downstream of the L2 cache tag bank and consumes its three eviction channels: tag_out_evict, set_out_evict and state_out_evict.
- Joins the three independently handshaken fields into one eviction record and buffers records in a small FIFO.
- Issues one writeback request per valid victim line to the memory-side port and tracks outstanding writebacks until they are acknowledged.
- Exports a busy flag that flush-completion logic uses to hold off flush_complete until all evictions drain.

Parameters:
TAG_W, 16, tag field width
SET_W, 8, set index width
STATE_W, 2, coherence state width (encoding from package)
DEPTH, 4, FIFO entries (power of 2, >=2)
MAX_OUT, 2, max unacknowledged writebacks (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
tag_out_evict_valid  in  1  victim tag valid
tag_out_evict_ready  out  1  victim tag ready
tag_out_evict_data  in  TAG_W  victim tag
set_out_evict_valid  in  1  victim set valid
set_out_evict_ready  out  1  victim set ready
set_out_evict_data  in  SET_W  victim set index
state_out_evict_valid  in  1  victim state valid
state_out_evict_ready  out  1  victim state ready
state_out_evict_data  in  STATE_W  victim coherence state
wb_req_valid  out  1  writeback request valid
wb_req_ready  in  1  memory side accepts request
wb_req_addr  out  TAG_W+SET_W  line address {tag,set}
wb_req_dirty  out  1  1 = data writeback, 0 = clean put
wb_ack  in  1  one-cycle pulse, one writeback retired
busy  out  1  any eviction held, queued or outstanding
drop_cnt  out  8  saturating count of INVALID-state records dropped
err_ack_underflow  out  1  sticky: wb_ack received with zero outstanding

Behaviour:
- Reset (rst low, async): all hold flags clear, FIFO empty, outstanding count 0, drop_cnt 0, err_ack_underflow 0, wb_req_valid 0, busy 0.
- While rst is low, all three *_ready outputs are forced to 0.
- Field capture: each input channel has a one-entry hold register plus a held flag.
  - A handshake (valid && ready) captures the data and sets held at the clock edge.
- Join: join_fire = held_tag && held_set && held_state && (state==INVALID || !full).
  - On join_fire all three held flags clear at that edge.
  - Each channel's ready = !held || join_fire, so a new field can be captured in the same cycle the old record leaves.
  - Channels can arrive in any order and cycle. A channel that arrives early waits, with its ready low, until the others arrive.
- Drop: if state==INVALID, join_fire still occurs but nothing is pushed. drop_cnt increments and saturates at 255.
- FIFO push: join_fire with state!=INVALID writes {tag,set,state}.
  - full is evaluated before any same-cycle pop, so a full FIFO never accepts a push even when a pop occurs in that cycle.
  - Occupancy counter is log2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- Output: wb_req_valid = !empty && out_cnt < MAX_OUT.
  - Addr, dirty and state are taken combinationally from the head entry.
  - wb_req_dirty = (state==MODIFIED).
  - Once wb_req_valid is asserted, it and its payload stay stable until wb_req_ready. The head cannot change without a pop, and out_cnt only rises on a pop.
- Pop: on wb_req_valid && wb_req_ready.
- Latency: with the FIFO empty, wb_req_valid rises in cycle t+2, where t is the cycle of the last field handshake.
- Outstanding counter (width clog2(MAX_OUT+1)):
  - +1 on pop.
  - -1 on wb_ack.
  - Pop and wb_ack in the same cycle leave it unchanged.
  - wb_ack when out_cnt==0 (and no same-cycle pop) is ignored and sets err_ack_underflow until reset.
- busy = any held flag || !empty || out_cnt != 0. It is a registered-state function with no combinational input path.
- Reset mid-operation discards held fields, queued records and outstanding counts. No request is emitted after reset until new fields are handshaken.

Decomposition:
- Package l2_cache_pkg holds:
  - the coherence state typedef and encodings: INVALID=0, SHARED=1, EXCLUSIVE=2, MODIFIED=3;
  - the evict_rec_t struct {tag,set,state};
  - default widths TAG_W, SET_W and STATE_W.
- One sub-module, l2_evict_fifo: a parameterised synchronous FIFO with push, pop, full, empty and head data, using the same async active-low reset.

Test Plan:
- Fields arrive in cycles 2, 5 and 3 (tag, set, state): tag=0x1A2B, set=0x07, state=MODIFIED, with wb_req_ready=1 -> wb_req_valid in cycle 7, addr=0x1A2B07, dirty=1; ready low on early channels until join.
- state=INVALID record -> no wb_req_valid; drop_cnt 0->1; after 260 such drops drop_cnt holds at 255.
- wb_req_ready=0, DEPTH+1 records offered -> 4 queued; 5th held with *_ready=0 until one pop; FIFO order preserved across pointer wrap.
- MAX_OUT=2, 3 queued, ready=1, no ack -> exactly 2 pops; wb_req_valid=0 until wb_ack; then third pops; busy drops 1 cycle after final ack.
- wb_ack with out_cnt=0 -> err_ack_underflow=1 and stays 1; out_cnt remains 0.
- rst asserted with 2 queued, 1 outstanding, tag held -> next cycle wb_req_valid=0, busy=0, all counters 0, readys 0; after release readys=1.
